// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the multicycle main controller and the MIPS datapath.
// The master side is the controller; the slave side is the datapath.
interface mc_main_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               state, instr_done, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               state, instr_done, illegal_op
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// and drives the datapath enables, mux selects and ALUOp.
module mc_main_ctrl (
    input  logic          clk,
    input  logic          rst,
    mc_main_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        LUI_EXEC  = 4'd10,
        LUI_WB    = 4'd11,
        JUMP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrca;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsource;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       done;
    } ctrl_t;

    state_t st;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   op_known;
    logic   fetch_go;
    logic   illegal;

    // Pure state-decoded controls; handshake-gated ones are added at the outputs.
    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:     begin c.memread = 1'b1; c.alusrcb = 2'b01; end
            DECODE:    c.alusrcb = 2'b11;
            MEM_ADDR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEM_READ:  begin c.memread = 1'b1; c.iord = 1'b1; end
            MEM_WB:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.done = 1'b1; end
            MEM_WRITE: begin c.memwrite = 1'b1; c.iord = 1'b1; end
            EXECUTE:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            R_WB:      begin c.regwrite = 1'b1; c.regdst = 1'b1; c.done = 1'b1; end
            BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop       = 2'b01;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
                c.done        = 1'b1;
            end
            LUI_EXEC:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b11; end
            LUI_WB:    begin c.regwrite = 1'b1; c.done = 1'b1; end
            JUMP:      begin c.pcwrite = 1'b1; c.pcsource = 2'b10; c.done = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = IDLE;
        case (st)
            IDLE:      nxt = FETCH;
            FETCH:     nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: nxt = MEM_ADDR;
                    OP_R:         nxt = EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_LUI:       nxt = LUI_EXEC;
                    OP_J:         nxt = JUMP;
                    default:      nxt = FETCH;
                endcase
            end
            MEM_ADDR:  nxt = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  nxt = bus.mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    nxt = FETCH;
            MEM_WRITE: nxt = bus.mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   nxt = R_WB;
            R_WB:      nxt = FETCH;
            BRANCH:    nxt = FETCH;
            LUI_EXEC:  nxt = LUI_WB;
            LUI_WB:    nxt = FETCH;
            JUMP:      nxt = FETCH;
            default:   nxt = IDLE;
        endcase
    end

    // Registering decode(nxt) keeps the Moore controls aligned with st.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            ctrl_q <= '0;
        end else begin
            st     <= nxt;
            ctrl_q <= decode(nxt);
        end
    end

    always_comb begin
        op_known = (bus.opcode == OP_R)   || (bus.opcode == OP_LW)  ||
                   (bus.opcode == OP_SW)  || (bus.opcode == OP_BEQ) ||
                   (bus.opcode == OP_LUI) || (bus.opcode == OP_J);
    end

    assign fetch_go = (st == FETCH) && bus.mem_ready;
    assign illegal  = (st == DECODE) && !op_known;

    assign bus.PCWrite     = ctrl_q.pcwrite | fetch_go;
    assign bus.IRWrite     = fetch_go;
    assign bus.PCWriteCond = ctrl_q.pcwritecond;
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemRead     = ctrl_q.memread;
    assign bus.MemWrite    = ctrl_q.memwrite;
    assign bus.MemtoReg    = ctrl_q.memtoreg;
    assign bus.ALUSrcA     = ctrl_q.alusrca;
    assign bus.RegWrite    = ctrl_q.regwrite;
    assign bus.RegDst      = ctrl_q.regdst;
    assign bus.PCSource    = ctrl_q.pcsource;
    assign bus.ALUSrcB     = ctrl_q.alusrcb;
    assign bus.ALUOp       = ctrl_q.aluop;
    assign bus.state       = st;
    assign bus.illegal_op  = illegal;
    assign bus.instr_done  = ctrl_q.done | illegal | ((st == MEM_WRITE) && bus.mem_ready);
endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: walks each opcode through its state sequence
// and checks state plus the full control word every cycle.
module tb_mc_main_ctrl;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    int   done_cnt;
    int   rw_cnt;
    int   ir_cnt;
    int   cyc_cnt;

    mc_main_ctrl_if bus();

    mc_main_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected control word from the per-state table, bit order as in ctrl_word().
    function automatic logic [17:0] ew(input int s, input bit rdy, input bit ill);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rwr, rdst, done, illo;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rwr, rdst, done, illo} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        case (s)
            1:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            2:  begin asb = 2'b11; done = ill; illo = ill; end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rwr = 1; m2r = 1; done = 1; end
            6:  begin mwr = 1; iord = 1; done = rdy; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rwr = 1; rdst = 1; done = 1; end
            9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            11: begin rwr = 1; done = 1; end
            12: begin pcw = 1; pcs = 2'b10; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rwr, rdst, pcs, asb, aop, done, illo};
    endfunction

    function automatic logic [17:0] ctrl_word();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.instr_done, bus.illegal_op};
    endfunction

    task automatic sample(input string tag, input int s, input bit ill);
        check({tag, ".state"}, 32'(bus.state), 32'(s));
        check({tag, ".ctrl"}, 32'(ctrl_word()), 32'(ew(s, bus.mem_ready, ill)));
        done_cnt += int'(bus.instr_done);
        rw_cnt   += int'(bus.RegWrite);
        ir_cnt   += int'(bus.IRWrite);
        cyc_cnt++;
    endtask

    task automatic cyc(input string tag, input int s, input bit ill = 1'b0);
        @(posedge clk);
        #1;
        sample(tag, s, ill);
    endtask

    task automatic clr();
        done_cnt = 0; rw_cnt = 0; ir_cnt = 0; cyc_cnt = 0;
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        sample("rst", 0, 1'b0);
        rst = 1'b0;
        cyc("rel", 1);

        // R-type, zero wait
        clr(); sample("r", 1, 1'b0);
        bus.opcode = 6'b000000;
        cyc("r", 2); cyc("r", 7); cyc("r", 8);
        check("r.cycles", 32'(cyc_cnt), 32'd4);
        check("r.done", 32'(done_cnt), 32'd1);
        cyc("r.next", 1);

        // lw with two stall cycles in MEM_READ
        clr(); sample("lw", 1, 1'b0);
        bus.opcode = 6'b100011;
        cyc("lw", 2); cyc("lw", 3);
        bus.mem_ready = 1'b0;
        cyc("lw", 4); cyc("lw", 4); cyc("lw", 4);
        bus.mem_ready = 1'b1;
        cyc("lw", 5);
        check("lw.cycles", 32'(cyc_cnt), 32'd7);
        check("lw.regwrite", 32'(rw_cnt), 32'd1);
        check("lw.done", 32'(done_cnt), 32'd1);
        cyc("lw.next", 1);

        // sw
        clr(); sample("sw", 1, 1'b0);
        bus.opcode = 6'b101011;
        cyc("sw", 2); cyc("sw", 3); cyc("sw", 6);
        check("sw.cycles", 32'(cyc_cnt), 32'd4);
        check("sw.done", 32'(done_cnt), 32'd1);
        cyc("sw.next", 1);

        // beq
        clr(); sample("beq", 1, 1'b0);
        bus.opcode = 6'b000100;
        cyc("beq", 2); cyc("beq", 9);
        check("beq.cycles", 32'(cyc_cnt), 32'd3);
        cyc("beq.next", 1);

        // lui
        clr(); sample("lui", 1, 1'b0);
        bus.opcode = 6'b001111;
        cyc("lui", 2); cyc("lui", 10); cyc("lui", 11);
        check("lui.cycles", 32'(cyc_cnt), 32'd4);
        check("lui.regwrite", 32'(rw_cnt), 32'd1);
        cyc("lui.next", 1);

        // j
        clr(); sample("j", 1, 1'b0);
        bus.opcode = 6'b000010;
        cyc("j", 2); cyc("j", 12);
        check("j.cycles", 32'(cyc_cnt), 32'd3);
        check("j.done", 32'(done_cnt), 32'd1);
        cyc("j.next", 1);

        // three-cycle fetch stall, then illegal opcode
        clr();
        bus.mem_ready = 1'b0;
        bus.opcode = 6'b111111;
        #1;
        sample("stall", 1, 1'b0);
        cyc("stall", 1); cyc("stall", 1);
        bus.mem_ready = 1'b1;
        #1;
        sample("stall.go", 1, 1'b0);
        check("stall.irwrite", 32'(ir_cnt), 32'd1);
        clr();
        cyc("ill", 2, 1'b1);
        check("ill.done", 32'(done_cnt), 32'd1);
        cyc("ill.next", 1);

        // reset while waiting in MEM_WRITE
        bus.opcode = 6'b101011;
        cyc("swr", 2); cyc("swr", 3);
        bus.mem_ready = 1'b0;
        cyc("swr", 6); cyc("swr", 6);
        rst = 1'b1;
        #1;
        sample("swr.rst", 0, 1'b0);
        check("swr.memwrite", 32'(bus.MemWrite), 32'd0);
        bus.mem_ready = 1'b1;
        cyc("swr.hold", 0);
        rst = 1'b0;
        cyc("swr.rel", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
